vram_scan_arbiter: RTL and testbench
====================================

Name: vram_scan_arbiter

Overview:
- Shares one single-port, synchronous-read pixel RAM (RGB444 framebuffer) between two requesters.
  - VGA scanout: real-time, never stalled.
  - Host/drawing port: uses a req/ack handshake.
- Sits between the 640x480 timing/scanout logic and the RAM, in the 25 MHz pixel-clock domain.
- Scanout has absolute priority. Host accesses fill idle cycles, mainly during blanking.
- Read data is routed back to its owner through a tagged, fixed-latency pipeline.

Parameters:
ADDR_W, 13, RAM word address width (80x60 cell framebuffer = 4800 words)
DATA_W, 12, RAM word width (RGB444)
STARVE_LIMIT, 1023, host wait cycles before HOST_STARVED asserts; must fit in 10 bits

Ports:
CLOCK_25M  in  1  pixel clock; all logic on rising edge
RESET_N  in  1  asynchronous, active-low reset
DISP_REQ  in  1  scanout read request this cycle
DISP_ADDR  in  ADDR_W  scanout read address
DISP_DATA  out  DATA_W  scanout read data
DISP_VALID  out  1  DISP_DATA valid pulse
HOST_REQ  in  1  host access request, level
HOST_WE  in  1  1 = write, 0 = read
HOST_ADDR  in  ADDR_W  host address
HOST_WDATA  in  DATA_W  host write data
HOST_ACK  out  1  grant pulse
HOST_RDATA  out  DATA_W  host read data
HOST_RVALID  out  1  HOST_RDATA valid pulse
HOST_STARVED  out  1  host waited STARVE_LIMIT cycles
RAM_EN  out  1  RAM enable
RAM_WE  out  1  RAM write enable
RAM_ADDR  out  ADDR_W  RAM address
RAM_WDATA  out  DATA_W  RAM write data
RAM_RDATA  in  DATA_W  RAM read data, registered inside RAM, 1-cycle latency

Behaviour:
- Reset values (RESET_N low): all outputs 0, FSM = IDLE, wait_cnt = 0, tag pipeline cleared.
- Reset mid-operation: in-flight reads are discarded. No VALID pulse may appear until a new grant after release.
- All outputs are registered.
- Decision is made at cycle t from inputs sampled at t. RAM command is driven at t+1.
- Arbitration, per cycle:
  - DISP_REQ=1: issue a display read (RAM_EN=1, RAM_WE=0, RAM_ADDR=DISP_ADDR) regardless of host state.
  - Else, if FSM=IDLE and HOST_REQ=1: issue the host access with HOST_WE, HOST_ADDR, HOST_WDATA.
  - Else: RAM_EN=0.
- Host handshake FSM:
  - IDLE: on host grant, go to ACKED with HOST_ACK=1 for exactly one cycle (same cycle as the RAM command).
  - ACKED: HOST_REQ is ignored. Return to IDLE unconditionally.
  - Host fields must be stable from HOST_REQ rise until HOST_ACK is sampled. Requester may present the next request the cycle after ACK.
  - Maximum host rate is one access per 2 cycles.
- Read return path:
  - 2-stage tag shift register {valid, owner} is loaded on each issued read; writes load valid=0.
  - Stage 2 output registers RAM_RDATA into DISP_DATA or HOST_RDATA and pulses the matching VALID.
  - Total latency is fixed: request sampled at t -> VALID at t+3, for both owners.
  - Host writes produce no RVALID.
  - Back-to-back display reads each cycle give a continuous DISP_VALID stream.
- Simultaneous DISP_REQ and HOST_REQ: display wins. Host stays pending with no ACK.
- Starvation counter wait_cnt (10 bits):
  - Increments each cycle HOST_REQ=1 with FSM=IDLE and no grant; saturates at STARVE_LIMIT.
  - HOST_STARVED=1 while wait_cnt==STARVE_LIMIT.
  - Cleared to 0 on host grant, or when HOST_REQ=0 in IDLE.
- DATA outputs hold their last value when VALID=0.

Test Plan:
- Reset: hold RESET_N=0 with DISP_REQ=1 and HOST_REQ=1 -> all outputs 0. Release -> first RAM_EN one cycle later, with RAM_ADDR=DISP_ADDR.
- Display stream: DISP_REQ=1 for 8 cycles, addresses 0..7, RAM model returns addr*3 -> DISP_VALID high 8 consecutive cycles starting t+3, DISP_DATA = 0,3,...,21. No HOST_RVALID.
- Host write then read: with DISP_REQ=0, HOST write 0x155 <- 0xABC -> HOST_ACK at t+1, RAM_WE=1. Then a read of 0x155 -> HOST_RVALID 3 cycles after its sample, HOST_RDATA=0xABC.
- Collision: DISP_REQ and HOST_REQ both high for 5 cycles, then DISP_REQ drops -> no HOST_ACK during overlap. ACK on the first free cycle. Display reads all returned in order.
- Starvation: STARVE_LIMIT=4, HOST_REQ held with DISP_REQ=1 -> HOST_STARVED rises after 4 waiting cycles and clears the cycle after the grant.
- Reset mid-flight: assert RESET_N low 1 cycle after a display read is issued -> no DISP_VALID after release.

Source files
------------

// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: shares one single-port, synchronous-read pixel RAM
// between VGA scanout (absolute priority, never stalled) and a host port
// using a req/ack handshake. Read data returns to its owner through a
// 2-stage {valid, owner} tag pipeline with a fixed 3-cycle latency.
//
// Ports:
//   CLOCK_25M, RESET_N          pixel clock, async active-low reset
//   DISP_REQ/DISP_ADDR          scanout read request
//   DISP_DATA/DISP_VALID        scanout read return
//   HOST_REQ/WE/ADDR/WDATA      host access request (level, held until ACK)
//   HOST_ACK                    one-cycle grant pulse
//   HOST_RDATA/HOST_RVALID      host read return
//   HOST_STARVED                host has waited STARVE_LIMIT cycles
//   RAM_EN/WE/ADDR/WDATA/RDATA  RAM command and registered read data
module vram_scan_arbiter #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned STARVE_LIMIT = 1023
) (
  input  logic              CLOCK_25M,
  input  logic              RESET_N,
  input  logic              DISP_REQ,
  input  logic [ADDR_W-1:0] DISP_ADDR,
  output logic [DATA_W-1:0] DISP_DATA,
  output logic              DISP_VALID,
  input  logic              HOST_REQ,
  input  logic              HOST_WE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [DATA_W-1:0] HOST_WDATA,
  output logic              HOST_ACK,
  output logic [DATA_W-1:0] HOST_RDATA,
  output logic              HOST_RVALID,
  output logic              HOST_STARVED,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA
);

  localparam int unsigned WAIT_W = 10;
  localparam logic [WAIT_W-1:0] STARVE_MAX = WAIT_W'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } state_t;

  // Return-path tag: valid read in flight, and whether the host owns it.
  typedef struct packed {
    logic valid;
    logic host;
  } tag_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  tag_t              tag_s1, tag_s2, tag_s1_nxt;
  logic              host_grant_c;
  logic              ram_en_nxt, ram_we_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_wdata_nxt;

  // Arbitration, handshake FSM and starvation counter next-state logic.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    host_grant_c  = 1'b0;
    tag_s1_nxt    = '0;
    ram_en_nxt    = 1'b0;
    ram_we_nxt    = 1'b0;
    ram_addr_nxt  = RAM_ADDR;
    ram_wdata_nxt = RAM_WDATA;

    case (state)
      IDLE: begin
        if (HOST_REQ && !DISP_REQ) begin
          host_grant_c = 1'b1;
          state_nxt    = ACKED;
          wait_cnt_nxt = '0;
        end else if (HOST_REQ) begin
          if (wait_cnt != STARVE_MAX) wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end else begin
          wait_cnt_nxt = '0;
        end
      end
      ACKED:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (DISP_REQ) begin
      ram_en_nxt       = 1'b1;
      ram_addr_nxt     = DISP_ADDR;
      tag_s1_nxt.valid = 1'b1;
      tag_s1_nxt.host  = 1'b0;
    end else if (host_grant_c) begin
      ram_en_nxt       = 1'b1;
      ram_we_nxt       = HOST_WE;
      ram_addr_nxt     = HOST_ADDR;
      ram_wdata_nxt    = HOST_WDATA;
      tag_s1_nxt.valid = !HOST_WE;
      tag_s1_nxt.host  = 1'b1;
    end
  end

  // State, RAM command, tag pipeline and return-data registers.
  always_ff @(posedge CLOCK_25M or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      tag_s1       <= '0;
      tag_s2       <= '0;
      RAM_EN       <= 1'b0;
      RAM_WE       <= 1'b0;
      RAM_ADDR     <= '0;
      RAM_WDATA    <= '0;
      HOST_ACK     <= 1'b0;
      HOST_STARVED <= 1'b0;
      DISP_VALID   <= 1'b0;
      DISP_DATA    <= '0;
      HOST_RVALID  <= 1'b0;
      HOST_RDATA   <= '0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      tag_s1       <= tag_s1_nxt;
      tag_s2       <= tag_s1;
      RAM_EN       <= ram_en_nxt;
      RAM_WE       <= ram_we_nxt;
      RAM_ADDR     <= ram_addr_nxt;
      RAM_WDATA    <= ram_wdata_nxt;
      HOST_ACK     <= host_grant_c;
      // Registered from the next count so it tracks wait_cnt cycle-exactly.
      HOST_STARVED <= (wait_cnt_nxt == STARVE_MAX);
      DISP_VALID   <= tag_s2.valid && !tag_s2.host;
      HOST_RVALID  <= tag_s2.valid && tag_s2.host;
      if (tag_s2.valid && !tag_s2.host) DISP_DATA  <= RAM_RDATA;
      if (tag_s2.valid && tag_s2.host)  HOST_RDATA <= RAM_RDATA;
    end
  end

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb_vram_scan_arbiter: directed bench for vram_scan_arbiter with a
// behavioural synchronous-read RAM whose contents start as addr*3.
module tb_vram_scan_arbiter;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 12;

  logic              CLOCK_25M = 1'b0;
  logic              RESET_N;
  logic              DISP_REQ;
  logic [ADDR_W-1:0] DISP_ADDR;
  logic [DATA_W-1:0] DISP_DATA;
  logic              DISP_VALID;
  logic              HOST_REQ;
  logic              HOST_WE;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic [DATA_W-1:0] HOST_WDATA;
  logic              HOST_ACK;
  logic [DATA_W-1:0] HOST_RDATA;
  logic              HOST_RVALID;
  logic              HOST_STARVED;
  logic              RAM_EN;
  logic              RAM_WE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_WDATA;
  logic [DATA_W-1:0] RAM_RDATA;

  int total = 0;
  int bad   = 0;

  vram_scan_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)
  ) dut (
    .CLOCK_25M(CLOCK_25M), .RESET_N(RESET_N),
    .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR),
    .DISP_DATA(DISP_DATA), .DISP_VALID(DISP_VALID),
    .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR),
    .HOST_WDATA(HOST_WDATA), .HOST_ACK(HOST_ACK),
    .HOST_RDATA(HOST_RDATA), .HOST_RVALID(HOST_RVALID),
    .HOST_STARVED(HOST_STARVED),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
    .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
  );

  always #20 CLOCK_25M = ~CLOCK_25M;

  // RAM model: refilled with addr*3 on clock edges while reset is held.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge CLOCK_25M) begin
    if (!RESET_N) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= DATA_W'(i * 3);
      RAM_RDATA <= '0;
    end else if (RAM_EN) begin
      if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
      RAM_RDATA <= mem[RAM_ADDR];
    end
  end

  task automatic tick();
    @(posedge CLOCK_25M);
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; DISP_REQ = 1'b1; DISP_ADDR = 13'h042;
    HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 13'h011; HOST_WDATA = 12'h5A5;
    repeat (3) tick();
    total++;
    if ({RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA, HOST_ACK, HOST_STARVED,
         HOST_RVALID, DISP_VALID, DISP_DATA, HOST_RDATA} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: en=%b we=%b addr=%h wd=%h ack=%b stv=%b rv=%b dv=%b dd=%h hd=%h want all 0",
               RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA, HOST_ACK, HOST_STARVED,
               HOST_RVALID, DISP_VALID, DISP_DATA, HOST_RDATA);
    end
    RESET_N = 1'b1;
    total++;
    if (RAM_EN !== 1'b0) begin bad++; $display("FAIL reset_release_en: got %b want 0", RAM_EN); end
    tick();
    total++;
    if (RAM_EN !== 1'b1) begin bad++; $display("FAIL reset_first_en: got %b want 1", RAM_EN); end
    total++;
    if (RAM_ADDR !== 13'h042) begin bad++; $display("FAIL reset_first_addr: got %h want 042", RAM_ADDR); end
    total++;
    if (RAM_WE !== 1'b0 || HOST_ACK !== 1'b0) begin
      bad++; $display("FAIL reset_first_cmd: we=%b ack=%b want 0 0", RAM_WE, HOST_ACK);
    end
    DISP_REQ = 1'b0; HOST_REQ = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_disp_stream();
    for (int cyc = 0; cyc <= 12; cyc++) begin
      logic              exp_v;
      logic              exp_en;
      logic [DATA_W-1:0] exp_d;
      exp_v  = (cyc >= 3 && cyc <= 10);
      exp_en = (cyc >= 1 && cyc <= 8);
      exp_d  = (cyc <= 10) ? DATA_W'((cyc - 3) * 3) : 12'd21;
      total++;
      if (DISP_VALID !== exp_v) begin
        bad++; $display("FAIL stream_valid c%0d: got %b want %b", cyc, DISP_VALID, exp_v);
      end
      total++;
      if (RAM_EN !== exp_en) begin
        bad++; $display("FAIL stream_ram_en c%0d: got %b want %b", cyc, RAM_EN, exp_en);
      end
      total++;
      if (HOST_RVALID !== 1'b0) begin
        bad++; $display("FAIL stream_host_rvalid c%0d: got %b want 0", cyc, HOST_RVALID);
      end
      if (cyc >= 3) begin
        total++;
        if (DISP_DATA !== exp_d) begin
          bad++; $display("FAIL stream_data c%0d: got %h want %h", cyc, DISP_DATA, exp_d);
        end
      end
      DISP_REQ  = (cyc < 8);
      DISP_ADDR = ADDR_W'(cyc);
      tick();
    end
    DISP_REQ = 1'b0;
  endtask

  task automatic test_host_wr_rd();
    DISP_REQ = 1'b0;
    HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 13'h155; HOST_WDATA = 12'hABC;
    tick();
    total++;
    if (HOST_ACK !== 1'b1) begin bad++; $display("FAIL wr_ack: got %b want 1", HOST_ACK); end
    total++;
    if ({RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA} !== {1'b1, 1'b1, 13'h155, 12'hABC}) begin
      bad++; $display("FAIL wr_cmd: en=%b we=%b addr=%h wd=%h want 1 1 155 abc",
                      RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA);
    end
    tick();
    total++;
    if (HOST_ACK !== 1'b0 || RAM_EN !== 1'b0) begin
      bad++; $display("FAIL acked_gap: ack=%b en=%b want 0 0", HOST_ACK, RAM_EN);
    end
    HOST_WE = 1'b0; HOST_WDATA = 12'h000;
    tick();
    total++;
    if (HOST_ACK !== 1'b1) begin bad++; $display("FAIL rd_ack: got %b want 1", HOST_ACK); end
    total++;
    if ({RAM_EN, RAM_WE, RAM_ADDR} !== {1'b1, 1'b0, 13'h155}) begin
      bad++; $display("FAIL rd_cmd: en=%b we=%b addr=%h want 1 0 155", RAM_EN, RAM_WE, RAM_ADDR);
    end
    total++;
    if (HOST_RVALID !== 1'b0) begin bad++; $display("FAIL wr_no_rvalid: got %b want 0", HOST_RVALID); end
    tick();
    HOST_REQ = 1'b0;
    total++;
    if (HOST_RVALID !== 1'b0 || HOST_ACK !== 1'b0) begin
      bad++; $display("FAIL rd_early: rvalid=%b ack=%b want 0 0", HOST_RVALID, HOST_ACK);
    end
    tick();
    total++;
    if (HOST_RVALID !== 1'b1) begin bad++; $display("FAIL rd_rvalid: got %b want 1", HOST_RVALID); end
    total++;
    if (HOST_RDATA !== 12'hABC) begin bad++; $display("FAIL rd_data: got %h want abc", HOST_RDATA); end
    total++;
    if (DISP_VALID !== 1'b0) begin bad++; $display("FAIL rd_disp_valid: got %b want 0", DISP_VALID); end
    tick();
    total++;
    if (HOST_RVALID !== 1'b0 || HOST_RDATA !== 12'hABC) begin
      bad++; $display("FAIL rd_hold: rvalid=%b data=%h want 0 abc", HOST_RVALID, HOST_RDATA);
    end
  endtask

  task automatic test_collision();
    for (int cyc = 0; cyc <= 10; cyc++) begin
      logic exp_ack;
      logic exp_dv;
      logic exp_hv;
      exp_ack = (cyc == 6);
      exp_dv  = (cyc >= 3 && cyc <= 7);
      exp_hv  = (cyc == 8);
      total++;
      if (HOST_ACK !== exp_ack) begin
        bad++; $display("FAIL coll_ack c%0d: got %b want %b", cyc, HOST_ACK, exp_ack);
      end
      total++;
      if (DISP_VALID !== exp_dv) begin
        bad++; $display("FAIL coll_disp_valid c%0d: got %b want %b", cyc, DISP_VALID, exp_dv);
      end
      total++;
      if (HOST_RVALID !== exp_hv) begin
        bad++; $display("FAIL coll_host_rvalid c%0d: got %b want %b", cyc, HOST_RVALID, exp_hv);
      end
      if (exp_dv) begin
        total++;
        if (DISP_DATA !== DATA_W'((32 + cyc - 3) * 3)) begin
          bad++; $display("FAIL coll_disp_data c%0d: got %h want %h", cyc, DISP_DATA,
                          DATA_W'((32 + cyc - 3) * 3));
        end
      end
      if (cyc == 6) begin
        total++;
        if (RAM_ADDR !== 13'h007) begin bad++; $display("FAIL coll_host_addr: got %h want 007", RAM_ADDR); end
      end
      if (cyc == 8) begin
        total++;
        if (HOST_RDATA !== 12'h015) begin bad++; $display("FAIL coll_host_data: got %h want 015", HOST_RDATA); end
      end
      DISP_REQ  = (cyc < 5);
      DISP_ADDR = ADDR_W'(32 + cyc);
      HOST_REQ  = (cyc <= 6);
      HOST_WE   = 1'b0;
      HOST_ADDR = 13'h007;
      tick();
    end
  endtask

  task automatic test_starve();
    for (int cyc = 0; cyc <= 9; cyc++) begin
      logic exp_stv;
      logic exp_ack;
      exp_stv = (cyc >= 4 && cyc <= 6);
      exp_ack = (cyc == 7);
      total++;
      if (HOST_STARVED !== exp_stv) begin
        bad++; $display("FAIL starve_flag c%0d: got %b want %b", cyc, HOST_STARVED, exp_stv);
      end
      total++;
      if (HOST_ACK !== exp_ack) begin
        bad++; $display("FAIL starve_ack c%0d: got %b want %b", cyc, HOST_ACK, exp_ack);
      end
      DISP_REQ   = (cyc <= 5);
      DISP_ADDR  = 13'h010;
      HOST_REQ   = (cyc <= 7);
      HOST_WE    = 1'b1;
      HOST_ADDR  = 13'h100;
      HOST_WDATA = 12'h123;
      tick();
    end
    DISP_REQ = 1'b0; HOST_REQ = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_midflight();
    DISP_REQ = 1'b1; DISP_ADDR = 13'h005;
    tick();
    DISP_REQ = 1'b0;
    total++;
    if (RAM_EN !== 1'b1 || RAM_ADDR !== 13'h005) begin
      bad++; $display("FAIL mid_issue: en=%b addr=%h want 1 005", RAM_EN, RAM_ADDR);
    end
    RESET_N = 1'b0;
    #1;
    total++;
    if (RAM_EN !== 1'b0) begin bad++; $display("FAIL mid_async_en: got %b want 0", RAM_EN); end
    #4;
    RESET_N = 1'b1;
    for (int cyc = 2; cyc <= 8; cyc++) begin
      tick();
      total++;
      if (DISP_VALID !== 1'b0 || HOST_RVALID !== 1'b0) begin
        bad++; $display("FAIL mid_no_valid c%0d: dv=%b hv=%b want 0 0", cyc, DISP_VALID, HOST_RVALID);
      end
      total++;
      if (DISP_DATA !== '0) begin
        bad++; $display("FAIL mid_data c%0d: got %h want 000", cyc, DISP_DATA);
      end
    end
  endtask

  initial begin
    RESET_N = 1'b0; DISP_REQ = 1'b0; DISP_ADDR = '0;
    HOST_REQ = 1'b0; HOST_WE = 1'b0; HOST_ADDR = '0; HOST_WDATA = '0;
    test_reset();
    test_disp_stream();
    test_host_wr_rd();
    test_collision();
    test_starve();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
